instr_encoder: RTL and testbench

//  Write-side counterpart of the main control decoder: accepts instruction fields over a valid/ready stream.

---
 rtl/instr_encoder.sv | 167 ++++++++++++++++
 tb/tb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Streams instruction fields into 32-bit MIPS words and writes them into imem in order,
// appending a "j self" halt word after the last instruction of a program.
module instr_encoder #(
  parameter int          ADDR_W    = 6,
  parameter int unsigned BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic              in_last,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LP_DEPTH = LP_ONE << ADDR_W;

  localparam logic [2:0] C_RTYPE = 3'd0;
  localparam logic [2:0] C_LW    = 3'd1;
  localparam logic [2:0] C_SW    = 3'd2;
  localparam logic [2:0] C_BEQ   = 3'd3;
  localparam logic [2:0] C_ADDI  = 3'd4;
  localparam logic [2:0] C_J     = 3'd5;

  typedef enum logic [1:0] {S_RUN, S_HALT, S_FULL, S_DONE} state_t;

  function automatic logic [31:0] encode(
    input logic [2:0]  cls,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (cls)
      C_RTYPE: w = {6'b000000, rs, rt, rd, 5'b00000, funct};
      C_LW:    w = {6'b100011, rs, rt, imm};
      C_SW:    w = {6'b101011, rs, rt, imm};
      C_BEQ:   w = {6'b000100, rs, rt, imm};
      C_ADDI:  w = {6'b001000, rs, rt, imm};
      C_J:     w = {6'b000010, target};
      default: w = '0;
    endcase
    return w;
  endfunction

  state_t            r_state, w_state_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wd, w_wd_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              r_err, w_err_nxt;
  logic              r_ovf, w_ovf_nxt;

  logic              w_accept;
  logic              w_legal;
  logic [ADDR_W:0]   w_count_inc;
  logic [25:0]       w_halt_tgt;

  assign in_ready    = (r_state == S_RUN) & ~clear;
  assign w_accept    = in_valid & in_ready;
  assign w_legal     = (in_class <= C_J);
  assign w_count_inc = r_count + LP_ONE;
  // Halt loop jumps to its own absolute word address.
  assign w_halt_tgt  = 26'(BASE_WORD) + 26'(r_count);

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wd_nxt    = r_wd;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_ovf_nxt   = r_ovf;
    if (clear) begin
      w_state_nxt = S_RUN;
      w_count_nxt = '0;
      w_err_nxt   = 1'b0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            if (w_legal) begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = r_count[ADDR_W-1:0];
              w_wd_nxt    = encode(in_class, in_rs, in_rt, in_rd, in_funct, in_imm, in_target);
              w_count_nxt = w_count_inc;
            end else begin
              w_err_nxt = 1'b1;
            end
            // An illegal last instruction still closes the program with a halt.
            if (in_last) begin
              w_state_nxt = S_HALT;
            end else if (w_legal && (w_count_inc == LP_DEPTH)) begin
              w_state_nxt = S_FULL;
            end
          end
        end
        S_HALT: begin
          if (r_count < LP_DEPTH) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_count[ADDR_W-1:0];
            w_wd_nxt    = {6'b000010, w_halt_tgt};
            w_count_nxt = w_count_inc;
          end else begin
            w_ovf_nxt = 1'b1;
          end
          w_state_nxt = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wd    <= w_wd_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign imem_we   = r_we;
  assign imem_addr = r_addr;
  assign imem_wd   = r_wd;
  assign count     = r_count;
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized program loads against a program-level model of the expected imem contents,
// plus directed reset/halt/illegal/full/overflow/clear/async-reset scenarios.
module tb_instr_encoder;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int BASE  = 'h40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_class = '0;
  logic          in_last = 1'b0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]    in_funct = '0;
  logic [15:0]   in_imm = '0;
  logic [25:0]   in_target = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic [AW:0]   count;
  logic          done, err, ovf;

  instr_encoder #(.ADDR_W(AW), .BASE_WORD(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_last(in_last), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .count(count), .done(done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Program under test and expected outcome
  int          p_cls[8];
  logic        p_last[8];
  logic [4:0]  p_rs[8], p_rt[8], p_rd[8];
  logic [5:0]  p_fn[8];
  logic [15:0] p_imm[8];
  logic [25:0] p_tgt[8];
  int          n_acc, e_count;
  logic        e_err, e_ovf, e_done, e_full;
  logic [31:0] q_addr[$];
  logic [31:0] q_wd[$];

  function automatic logic [31:0] ref_enc(input int i);
    logic [31:0] rsrt;
    rsrt = (32'(p_rs[i]) << 21) + (32'(p_rt[i]) << 16);
    case (p_cls[i])
      0: return rsrt + (32'(p_rd[i]) << 11) + 32'(p_fn[i]);
      1: return (32'd35 << 26) + rsrt + 32'(p_imm[i]);
      2: return (32'd43 << 26) + rsrt + 32'(p_imm[i]);
      3: return (32'd4 << 26) + rsrt + 32'(p_imm[i]);
      4: return (32'd8 << 26) + rsrt + 32'(p_imm[i]);
      default: return (32'd2 << 26) + 32'(p_tgt[i]);
    endcase
  endfunction

  task automatic model_prog(input int n);
    int wa;
    bit legal;
    wa = 0; n_acc = 0;
    e_err = 0; e_ovf = 0; e_done = 0; e_full = 0;
    for (int i = 0; i < n; i++) begin
      n_acc++;
      legal = (p_cls[i] <= 5);
      if (legal) begin
        q_addr.push_back(32'(wa));
        q_wd.push_back(ref_enc(i));
        wa++;
      end else begin
        e_err = 1;
      end
      if (p_last[i]) begin
        if (wa < DEPTH) begin
          q_addr.push_back(32'(wa));
          q_wd.push_back(32'h0800_0000 | ((BASE + wa) & 32'h03FF_FFFF));
          wa++;
        end else begin
          e_ovf = 1;
        end
        e_done = 1;
        break;
      end
      if (legal && wa == DEPTH) begin
        e_full = 1;
        break;
      end
    end
    e_count = wa;
  endtask

  task automatic set_instr(input int i, input int cls, input logic last);
    p_cls[i] = cls; p_last[i] = last;
    p_rs[i] = 5'($urandom); p_rt[i] = 5'($urandom); p_rd[i] = 5'($urandom);
    p_fn[i] = 6'($urandom); p_imm[i] = 16'($urandom); p_tgt[i] = 26'($urandom);
  endtask

  task automatic send(input int i);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    in_class = 3'(p_cls[i]); in_last = p_last[i];
    in_rs = p_rs[i]; in_rt = p_rt[i]; in_rd = p_rd[i];
    in_funct = p_fn[i]; in_imm = p_imm[i]; in_target = p_tgt[i];
    in_valid = 1'b1;
    #1 check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic finish_prog();
    repeat (4) @(negedge clk);
    #1;
    check_eq("count", 32'(count), 32'(e_count));
    check_eq("err", 32'(err), 32'(e_err));
    check_eq("ovf", 32'(ovf), 32'(e_ovf));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("in_ready_end", 32'(in_ready), 32'(!(e_done || e_full)));
    check_eq("pending_writes", 32'(q_wd.size()), 32'd0);
    q_wd.delete(); q_addr.delete();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1 check_eq("in_ready_during_clear", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic run_prog(input int n);
    model_prog(n);
    for (int i = 0; i < n_acc; i++) send(i);
    finish_prog();
  endtask

  // Every observed write must be the next one the model expects
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (q_wd.size() == 0) begin
        check_eq("spurious_we", 32'(imem_we), 32'd0);
      end else begin
        check_eq("wr_addr", 32'(imem_addr), q_addr.pop_front());
        check_eq("wr_wd", imem_wd, q_wd.pop_front());
      end
    end
  end

  initial begin
    #2;
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_wd", imem_wd, 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_flags", {29'd0, done, err, ovf}, 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    // LW right after reset
    set_instr(0, 1, 1'b0);
    p_rs[0] = 5'd2; p_rt[0] = 5'd3; p_imm[0] = 16'h0010;
    model_prog(1);
    send(0);
    check_eq("lw_we", 32'(imem_we), 32'd1);
    check_eq("lw_addr", 32'(imem_addr), 32'd0);
    check_eq("lw_wd", imem_wd, 32'h8C43_0010);
    check_eq("lw_count", 32'(count), 32'd1);
    finish_prog();

    // R-type last, followed by halt
    do_clear();
    set_instr(0, 0, 1'b1);
    p_rs[0] = 5'd1; p_rt[0] = 5'd2; p_rd[0] = 5'd3; p_fn[0] = 6'h20;
    model_prog(1);
    send(0);
    check_eq("r_wd", imem_wd, 32'h0022_1820);
    finish_prog();

    // Illegal class consumed without write; next word at same slot
    do_clear();
    set_instr(0, 7, 1'b0);
    set_instr(1, 1, 1'b0);
    model_prog(2);
    send(0);
    check_eq("illegal_no_we", 32'(imem_we), 32'd0);
    check_eq("illegal_err", 32'(err), 32'd1);
    check_eq("illegal_count", 32'(count), 32'd0);
    send(1);
    finish_prog();

    // Fill memory without last -> FULL
    do_clear();
    for (int i = 0; i < 4; i++) set_instr(i, $urandom_range(0, 5), 1'b0);
    run_prog(4);

    // Last lands in final slot -> halt dropped
    do_clear();
    for (int i = 0; i < 4; i++) set_instr(i, $urandom_range(0, 5), i == 3);
    run_prog(4);

    // Clear on the cycle after an accept
    do_clear();
    set_instr(0, 6, 1'b0);
    set_instr(1, 2, 1'b0);
    model_prog(2);
    send(0);
    send(1);
    clear = 1'b1;
    #1 check_eq("clear_gates_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    check_eq("clear_count", 32'(count), 32'd0);
    check_eq("clear_err", 32'(err), 32'd0);
    @(negedge clk);
    #1 check_eq("clear_write_issued", 32'(q_wd.size()), 32'd0);
    set_instr(0, 0, 1'b1);
    run_prog(1);

    // Random programs
    for (int k = 0; k < 40; k++) begin
      int n;
      do_clear();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        set_instr(i, $urandom_range(0, 7), (i == n - 1) && ($urandom_range(0, 3) != 0));
      run_prog(n);
    end

    // Asynchronous reset mid-stream
    do_clear();
    set_instr(0, 4, 1'b0);
    model_prog(1);
    send(0);
    rst_n = 1'b0;
    #1;
    check_eq("async_we", 32'(imem_we), 32'd0);
    check_eq("async_count", 32'(count), 32'd0);
    check_eq("async_wd", imem_wd, 32'd0);
    q_wd.delete(); q_addr.delete();
    @(negedge clk) rst_n = 1'b1;
    #1 check_eq("async_ready_after", 32'(in_ready), 32'd1);
    set_instr(0, 3, 1'b1);
    run_prog(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
